// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_pkg: shared types for the shift-ALU sequencer.
// Holds the request op encodings, the sequencer FSM state enum and
// small helpers used to size counters and to predict ALU read data.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_SHIFT = 2'b00,   // load shift amount (addr0 strobe)
      OP_PUSH  = 2'b01,   // push FIFO byte (addr1 strobe)
      OP_READ  = 2'b10,   // read ALU result (mode low)
      OP_RSVD  = 2'b11    // accepted, no ALU activity
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_TURN1  = 3'd4,
      ST_READ   = 3'd5,
      ST_TURN2  = 3'd6,
      ST_RSVD   = 3'd7
   } state_t;

   // Largest of the four phase lengths; sets the shared down-counter width.
   function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b,
                                           input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Result the ALU should present: the upper byte of {f1,f0} shifted left.
   // A shift of 0 yields f1; otherwise (f1<<s)|(f0>>(8-s)) truncated to 8 bits.
   function automatic logic [7:0] shadow_expect(input logic [2:0] sh,
                                                input logic [7:0] f0,
                                                input logic [7:0] f1);
      logic [15:0] pair;
      pair = {f1, f0} << sh;
      return pair[15:8];
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: request/response bus between the core fabric and the
// ALU sequencer.
//
// Handshake: a requester raises x_valid with x_op/x_wdata stable and keeps
// all three unchanged until it sees x_ready high; the transfer happens on
// the rising clock edge where x_valid and x_ready are both high. x_ready is
// a one-cycle pulse. rsp_valid is a one-cycle pulse with no back-pressure;
// rsp_port/rsp_data are meaningful only while rsp_valid is high.
interface alu_seq_ctrl_if;

   logic       a_valid;
   logic       a_ready;
   logic [1:0] a_op;
   logic [7:0] a_wdata;

   logic       b_valid;
   logic       b_ready;
   logic [1:0] b_op;
   logic [7:0] b_wdata;

   logic       rsp_valid;
   logic       rsp_port;
   logic [7:0] rsp_data;

   modport master (
      output a_valid, a_op, a_wdata,
      output b_valid, b_op, b_wdata,
      input  a_ready, b_ready,
      input  rsp_valid, rsp_port, rsp_data
   );

   modport slave (
      input  a_valid, a_op, a_wdata,
      input  b_valid, b_op, b_wdata,
      output a_ready, b_ready,
      output rsp_valid, rsp_port, rsp_data
   );

endinterface

// File: rtl/alu_seq_ctrl_rr_arb.sv
// alu_seq_rr_arb: two-port round-robin arbiter.
// gnt is a combinational one-hot pick among the requesting ports; when the
// sequencer commits a grant (adv) the priority pointer moves to the port
// that was not granted. A lone requester always wins.
module alu_seq_rr_arb (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       adv,
   output logic [1:0] gnt
);

   logic ptr;   // 0: port A has priority, 1: port B has priority

   // Pick a winner; the pointer only matters when both ports request.
   always_comb begin
      gnt = 2'b00;
      if (req[0] && req[1]) gnt = ptr ? 2'b10 : 2'b01;
      else if (req[0])      gnt = 2'b01;
      else if (req[1])      gnt = 2'b10;
   end

   // Pointer moves past whichever port was just granted.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                ptr <= 1'b0;
      else if (adv && (|gnt))    ptr <= gnt[0];
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: shares the protection shift-ALU between CPU port A and the
// stream-loader port B. Each accepted request becomes a timed sequence of
// data-bus drive, addr0/addr1 strobe and mode cycles on the ALU pins, and
// the controller never drives the data bus while the ALU may be driving it.
//
// Optional build macro ALU_SHADOW_CHECK_EN: keeps a shadow of the ALU state
// and raises a sticky chk_err when read data disagrees with it. Without the
// macro the chk_err port and shadow logic are not present.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned PULSE_CYC = 2,
   parameter int unsigned HOLD_CYC  = 1,
   parameter int unsigned READ_CYC  = 2
) (
   input  logic          clk,
   input  logic          reset,
   alu_seq_ctrl_if.slave bus,
   output logic [7:0]    alu_dout,
   output logic          alu_doe,
   input  logic [7:0]    alu_din,
   output logic          alu_addr0,
   output logic          alu_addr1,
   output logic          alu_mode,
   output logic          alu_rst_n,
   output logic          busy,
   output state_t        state_dbg
`ifdef ALU_SHADOW_CHECK_EN
   ,
   output logic          chk_err
`endif
);

   localparam int unsigned CNT_MAX = cyc_max(SETUP_CYC, PULSE_CYC, HOLD_CYC, READ_CYC);
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
   localparam logic [CW-1:0] READ_LD  = CW'(READ_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = '0;

   state_t        state;
   logic [CW-1:0] cnt;
   op_t           op_q;
   logic          port_q;

   logic          a_rdy_q;
   logic          b_rdy_q;
   logic          rsp_valid_q;
   logic          rsp_port_q;
   logic [7:0]    rsp_data_q;

   logic [1:0]    gnt;
   logic          grant_cycle;
   logic          last_cyc;
   logic          arb_adv;
   op_t           sel_op;
   logic [7:0]    sel_wdata;

   assign bus.a_ready   = a_rdy_q;
   assign bus.b_ready   = b_rdy_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_port  = rsp_port_q;
   assign bus.rsp_data  = rsp_data_q;
   assign state_dbg     = state;

   // The cycle where ready is high is the grant cycle; op/wdata come from
   // the granted port and are taken at the end of it.
   assign grant_cycle = a_rdy_q | b_rdy_q;
   assign sel_op      = op_t'(b_rdy_q ? bus.b_op : bus.a_op);
   assign sel_wdata   = b_rdy_q ? bus.b_wdata : bus.a_wdata;

   // Arbitrate in an idle, non-grant cycle, or on the final cycle of an
   // operation so the next grant lands on the first IDLE cycle.
   assign last_cyc = ((state == ST_HOLD) && (cnt == CNT_ZERO)) ||
                     (state == ST_TURN2) || (state == ST_RSVD);
   assign arb_adv  = (((state == ST_IDLE) && !grant_cycle) || last_cyc) && (|gnt);

   alu_seq_rr_arb u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({bus.b_valid, bus.a_valid}),
      .adv   (arb_adv),
      .gnt   (gnt)
   );

   // Sequencer FSM: every ALU pin, handshake and response output is a register here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= CNT_ZERO;
         op_q        <= OP_SHIFT;
         port_q      <= 1'b0;
         a_rdy_q     <= 1'b0;
         b_rdy_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_port_q  <= 1'b0;
         rsp_data_q  <= 8'h00;
         alu_dout    <= 8'h00;
         alu_doe     <= 1'b0;
         alu_addr0   <= 1'b0;
         alu_addr1   <= 1'b0;
         alu_mode    <= 1'b1;
         alu_rst_n   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         alu_rst_n   <= 1'b1;
         a_rdy_q     <= 1'b0;
         b_rdy_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_port_q  <= 1'b0;
         rsp_data_q  <= 8'h00;
         if (arb_adv) begin
            a_rdy_q <= gnt[0];
            b_rdy_q <= gnt[1];
         end

         case (state)
            ST_IDLE: begin
               if (grant_cycle) begin
                  port_q <= b_rdy_q;
                  op_q   <= sel_op;
                  busy   <= 1'b1;
                  case (sel_op)
                     OP_SHIFT, OP_PUSH: begin
                        state    <= ST_SETUP;
                        cnt      <= SETUP_LD;
                        alu_doe  <= 1'b1;
                        alu_dout <= sel_wdata;
                     end
                     OP_READ: begin
                        state <= ST_TURN1;
                     end
                     default: begin
                        state       <= ST_RSVD;
                        rsp_valid_q <= 1'b1;
                        rsp_port_q  <= b_rdy_q;
                     end
                  endcase
               end
            end

            ST_SETUP: begin
               if (cnt == CNT_ZERO) begin
                  state <= ST_STROBE;
                  cnt   <= PULSE_LD;
                  if (op_q == OP_SHIFT) alu_addr0 <= 1'b1;
                  else                  alu_addr1 <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            ST_STROBE: begin
               if (cnt == CNT_ZERO) begin
                  state     <= ST_HOLD;
                  cnt       <= HOLD_LD;
                  alu_addr0 <= 1'b0;
                  alu_addr1 <= 1'b0;
                  if (HOLD_CYC == 1) begin
                     rsp_valid_q <= 1'b1;
                     rsp_port_q  <= port_q;
                  end
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            ST_HOLD: begin
               if (cnt == CNT_ZERO) begin
                  state    <= ST_IDLE;
                  busy     <= 1'b0;
                  alu_doe  <= 1'b0;
                  alu_dout <= 8'h00;
               end else begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     rsp_valid_q <= 1'b1;
                     rsp_port_q  <= port_q;
                  end
               end
            end

            ST_TURN1: begin
               state    <= ST_READ;
               cnt      <= READ_LD;
               alu_mode <= 1'b0;
            end

            ST_READ: begin
               if (cnt == CNT_ZERO) begin
                  state       <= ST_TURN2;
                  alu_mode    <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  rsp_port_q  <= port_q;
                  rsp_data_q  <= alu_din;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end

            ST_TURN2: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            ST_RSVD: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef ALU_SHADOW_CHECK_EN
   logic [2:0] sh_shift;
   logic [7:0] sh_f0;
   logic [7:0] sh_f1;

   // Track ALU state from completed writes and flag any read that disagrees.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_shift <= 3'd0;
         sh_f0    <= 8'h00;
         sh_f1    <= 8'h00;
         chk_err  <= 1'b0;
      end else begin
         if ((state == ST_HOLD) && (cnt == CNT_ZERO)) begin
            if (op_q == OP_SHIFT) begin
               sh_shift <= alu_dout[2:0];
            end else begin
               sh_f0 <= sh_f1;
               sh_f1 <= alu_dout;
            end
         end
         if ((state == ST_READ) && (cnt == CNT_ZERO) &&
             (alu_din != shadow_expect(sh_shift, sh_f0, sh_f1))) begin
            chk_err <= 1'b1;
         end
      end
   end
`endif

endmodule
